alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, the width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  command present.
REQ-005 SHALL have port in_ready  output  1  command accepted when in_valid && in_ready at a rising edge.
REQ-006 SHALL have port in_op  input  4  opcode.
REQ-007 SHALL have port in_a  input  8  operand A.
REQ-008 SHALL have port in_b  input  8  operand B.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at a rising edge.
REQ-011 SHALL have port out_z  output  8  result.
REQ-012 SHALL have port out_illegal  output  1  result came from an undefined opcode.
REQ-013 SHALL have port op_count  output  COUNT_W  number of completed output handshakes.

Function
REQ-014 SHALL use these opcodes: 0 -> 8'h00; 1 -> 8'h01; 2 -> A; 3 -> B; 4 -> (A+B) mod 256, carry dropped; 5 -> (~A+1) mod 256, so 8'h00->8'h00 and 8'h80->8'h80; 6 -> A&B; 7 -> A|B; 8 -> 8'h01 if A==B, else 8'h00; 9 -> 8'h01 if A>B unsigned, else 8'h00.
REQ-015 SHALL, for opcodes 10-15, produce out_z=8'h00 with out_illegal=1; out_illegal SHALL be 0 for all other opcodes.
REQ-016 SHALL be a two-stage pipeline: stage 1 registers op/A/B; stage 2 registers out_z/out_illegal/out_valid.
REQ-017 SHALL assert out_valid on the second rising edge after acceptance when there is no stall, giving a latency of 2 cycles.
REQ-018 SHALL sustain one command per cycle while out_ready=1.
REQ-019 SHALL drive in_ready = !s1_valid || !out_valid || out_ready; this is a combinational path from out_ready, and the spec permits it.
REQ-020 SHALL, while out_valid=1 and out_ready=0, hold out_z/out_illegal stable and keep stage 1 occupied; with both stages full, in_ready SHALL be 0.
REQ-021 SHALL never drop, duplicate or reorder commands; results SHALL emerge in acceptance order.
REQ-022 SHALL, when stage 2 is emptied and a new command is accepted in the same cycle, move stage 1 to stage 2 and load the new command into stage 1.
REQ-023 SHALL increment op_count by 1 on each output handshake, wrapping from 2^COUNT_W-1 to 0.
REQ-024 SHALL ignore in_op/in_a/in_b when in_valid=0 and hold out_z when out_valid=0.

Reset
REQ-025 SHALL, on rst assertion and independent of clk, clear s1_valid, out_valid, out_z (8'h00), out_illegal (0) and op_count (0).
REQ-026 SHALL hold in_ready at 0 while rst=1.
REQ-027 SHALL discard in-flight commands when reset is asserted mid-operation, with no partial result emitted afterwards.
REQ-028 SHALL accept a command on the first rising edge after rst deasserts.

Structure
REQ-029 SHALL take the opcode constants (OP_ZERO..OP_GT), the data width 8 and the opcode width 4 from shared package alu_pkg.
REQ-030 SHALL instantiate the existing combinational alu (OP, A, B -> Z) as its sole sub-module for the stage-2 compute.
REQ-031 SHALL perform illegal-opcode detection in alu_pipe itself.

Verification
REQ-032 SHALL cover: back-to-back A=8'hAA,B=8'h0F with ops 4,5, then A=8'h55,B=8'hF0 with ops 6,7, all with out_ready=1 -> out_z = 8'hB9, 8'h56, 8'h50, 8'hF5 on consecutive cycles, first result 2 cycles after acceptance.
REQ-033 SHALL cover: op 8 with A=B=8'h0F -> 8'h01; op 9 with A=8'h0F,B=8'h00 -> 8'h01; op 9 with A=8'h00,B=8'h0F -> 8'h00; op 5 with A=8'h80 -> 8'h80.
REQ-034 SHALL cover: out_ready=0 for 4 cycles while 3 commands are offered -> 2 accepted, then in_ready=0 and out_z held; on release, all 3 results appear in order with none lost.
REQ-035 SHALL cover: op 4'hC with any operands -> out_z=8'h00, out_illegal=1; the following op 1 -> out_z=8'h01, out_illegal=0.
REQ-036 SHALL cover: COUNT_W=4 with 17 handshakes -> op_count reads 1, having wrapped through 0.
REQ-037 SHALL cover: rst pulsed between clock edges with both stages full -> out_valid=0, op_count=0 immediately, and no stale result after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths and opcode encodings for the ALU and its pipelined wrapper.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ZERO   = 4'd0;
  localparam logic [OP_W-1:0] OP_ONE    = 4'd1;
  localparam logic [OP_W-1:0] OP_PASS_A = 4'd2;
  localparam logic [OP_W-1:0] OP_PASS_B = 4'd3;
  localparam logic [OP_W-1:0] OP_ADD    = 4'd4;
  localparam logic [OP_W-1:0] OP_NEG    = 4'd5;
  localparam logic [OP_W-1:0] OP_AND    = 4'd6;
  localparam logic [OP_W-1:0] OP_OR     = 4'd7;
  localparam logic [OP_W-1:0] OP_EQ     = 4'd8;
  localparam logic [OP_W-1:0] OP_GT     = 4'd9;

endpackage

// File: rtl/alu.sv
// Purely combinational 8-bit ALU; undefined opcodes yield zero.
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] z
);

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    z = '0;
    case (op)
      OP_ZERO:   z = 8'h00;
      OP_ONE:    z = 8'h01;
      OP_PASS_A: z = a;
      OP_PASS_B: z = b;
      OP_ADD:    z = a + b;
      OP_NEG:    z = ~a + 8'h01;
      OP_AND:    z = a & b;
      OP_OR:     z = a | b;
      OP_EQ:     z = (a == b) ? 8'h01 : 8'h00;
      OP_GT:     z = (a > b) ? 8'h01 : 8'h00;
      default:   z = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipeline around alu: stage 1 holds the command,
// stage 2 holds the result, with a counter of completed output handshakes.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]  in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_z,
  output logic               out_illegal,
  output logic [COUNT_W-1:0] op_count
);

  logic              s1_valid;
  logic [OP_W-1:0]   s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [DATA_W-1:0] alu_z;
  logic              s1_illegal;
  logic              s2_free;
  logic              accept;

  // Stage 2 can take a new result when empty or being drained this cycle.
  assign s2_free    = !out_valid || out_ready;
  assign in_ready   = !rst && (!s1_valid || s2_free);
  assign accept     = in_valid && in_ready;
  assign s1_illegal = (s1_op > OP_GT);

  alu u_alu (
    .op (s1_op),
    .a  (s1_a),
    .b  (s1_b),
    .z  (alu_z)
  );

  // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      out_valid   <= 1'b0;
      out_z       <= '0;
      out_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      if (out_valid && out_ready) op_count <= op_count + COUNT_W'(1);

      if (s2_free) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_z       <= s1_illegal ? '0 : alu_z;
          out_illegal <= s1_illegal;
        end
      end

      if (accept)       s1_valid <= 1'b1;
      else if (s2_free) s1_valid <= 1'b0;
    end
  end

  // NOTE: payload registers carry no reset; s1_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op <= in_op;
      s1_a  <= in_a;
      s1_b  <= in_b;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe with a result scoreboard; COUNT_W=4 exercises counter wrap.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = '0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_z;
  logic       out_illegal;
  logic [3:0] op_count;

  typedef struct packed {
    logic [7:0] z;
    logic       illegal;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] cnt_model = '0;
  int         n_checks  = 0;
  int         n_errors  = 0;
  bit         acc;

  alu_pipe #(.COUNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_z       (out_z),
    .out_illegal (out_illegal),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.illegal = 1'b0;
    case (op)
      4'd0:    e.z = 8'h00;
      4'd1:    e.z = 8'h01;
      4'd2:    e.z = a;
      4'd3:    e.z = b;
      4'd4:    e.z = 8'((9'(a) + 9'(b)) % 9'd256);
      4'd5:    e.z = 8'h00 - a;
      4'd6:    e.z = a & b;
      4'd7:    e.z = a | b;
      4'd8:    e.z = (a == b) ? 8'h01 : 8'h00;
      4'd9:    e.z = (a > b) ? 8'h01 : 8'h00;
      default: begin e.z = 8'h00; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshakes are judged on settled values mid-cycle; the counter is checked just after the edge.
  task automatic tick(output bit accepted);
    exp_t e;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back(model(in_op, in_a, in_b));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_z", {24'b0, out_z}, {24'b0, e.z});
        check("out_illegal", {31'b0, out_illegal}, {31'b0, e.illegal});
      end
      cnt_model = cnt_model + 4'd1;
    end
    @(posedge clk);
    #1;
    check("op_count", {28'b0, op_count}, {28'b0, cnt_model});
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 20 && !got; i++) tick(got);
    check("accept_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic drain();
    bit dummy;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) tick(dummy);
    check("drain_queue_empty", sb.size(), 32'd0);
  endtask

  initial begin
    // Reset state, applied without a clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_z", {24'b0, out_z}, 32'd0);
    check("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
    check("rst_op_count", {28'b0, op_count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back stream with latency check.
    in_valid = 1'b1; in_op = 4'd4; in_a = 8'hAA; in_b = 8'h0F;
    #1 check("ready_after_reset", {31'b0, in_ready}, 32'd1);
    send(4'd4, 8'hAA, 8'h0F);
    check("lat_not_yet_valid", {31'b0, out_valid}, 32'd0);
    send(4'd5, 8'hAA, 8'h0F);
    check("lat_valid_2nd_edge", {31'b0, out_valid}, 32'd1);
    check("lat_first_z", {24'b0, out_z}, 32'h000000B9);
    send(4'd6, 8'h55, 8'hF0);
    check("stream_z2", {24'b0, out_z}, 32'h00000056);
    send(4'd7, 8'h55, 8'hF0);
    check("stream_z3", {24'b0, out_z}, 32'h00000050);
    drain();

    // Compare and negate boundaries, plus the simple opcodes.
    send(4'd8, 8'h0F, 8'h0F);
    send(4'd9, 8'h0F, 8'h00);
    send(4'd9, 8'h00, 8'h0F);
    send(4'd5, 8'h80, 8'h33);
    send(4'd5, 8'h00, 8'h00);
    send(4'd0, 8'h12, 8'h34);
    send(4'd2, 8'h12, 8'h34);
    send(4'd3, 8'h12, 8'h34);
    send(4'd4, 8'hFF, 8'h02);
    // Illegal opcode followed by a legal one.
    send(4'hC, 8'h5A, 8'hA5);
    send(4'd1, 8'h00, 8'h00);
    send(4'hF, 8'hFF, 8'hFF);
    send(4'd1, 8'h77, 8'h66);
    drain();
    check("hold_z_when_idle", {24'b0, out_z}, 32'h00000001);

    // Back-pressure: three commands offered while out_ready is low for four cycles.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd2; in_a = 8'h11; in_b = 8'h00;
    tick(acc);
    check("stall_acc0", {31'b0, acc}, 32'd1);
    in_op = 4'd3; in_a = 8'h00; in_b = 8'h22;
    tick(acc);
    check("stall_acc1", {31'b0, acc}, 32'd1);
    in_op = 4'd7; in_a = 8'h30; in_b = 8'h03;
    tick(acc);
    check("stall_acc2_refused", {31'b0, acc}, 32'd0);
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    check("stall_z_held_a", {24'b0, out_z}, 32'h00000011);
    tick(acc);
    check("stall_acc3_refused", {31'b0, acc}, 32'd0);
    check("stall_z_held_b", {24'b0, out_z}, 32'h00000011);
    check("stall_valid_held", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    send(4'd7, 8'h30, 8'h03);
    drain();

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(4'd2, 8'hDE, 8'h00);
    send(4'd2, 8'hAD, 8'h00);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_op_count", {28'b0, op_count}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    #1 rst = 1'b0;
    sb.delete();
    cnt_model = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      check("no_stale_result", {31'b0, out_valid}, 32'd0);
    end

    // Counter wrap: 17 handshakes on a 4-bit counter.
    for (int i = 0; i < 17; i++) send(4'(i % 10), 8'(i * 7), 8'(i * 3));
    drain();
    check("op_count_wrap", {28'b0, op_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
